// File: rtl/cpu_stack_writeback.sv
// rtl/cpu_stack_writeback.sv - stage-4 operand stack writeback: pop, optional tagged push, registered TOS/NOS/depth and sticky faults
module cpu_stack_writeback #(
    parameter int         DEPTH      = 16,
    parameter int         DW         = 5,
    parameter logic [1:0] UC_PUSHALU = 2'd1,
    parameter logic [1:0] UC_PUSHIMM = 2'd2
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [1:0]    c__to_push_4a,
    input  logic [31:0]   pc_4a,
    input  logic [10:0]   st__to_pop_4a,
    input  logic [34:0]   st__to_push_4a,
    output logic [34:0]   st__tos,
    output logic [34:0]   st__nos,
    output logic [DW-1:0] st__depth,
    output logic          st__underflow,
    output logic          st__overflow,
    output logic [31:0]   st__fault_pc
);
    localparam int AW = DW - 1;

    logic [34:0]   mem_q [DEPTH];
    logic [34:0]   mem_d [DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    logic [34:0]   tos_q, tos_d, nos_q, nos_d;
    logic          underflow_q, underflow_d, overflow_q, overflow_d;
    logic [31:0]   fault_pc_q, fault_pc_d;

    logic [1:0]    pop_cnt;
    logic          push_en, wr_en, uf_ev, of_ev;
    logic [DW-1:0] d1, d2, tos_idx, nos_idx;
    logic          unused_pop_bits;

    assign unused_pop_bits = ^st__to_pop_4a[10:2];

    always_comb begin
        pop_cnt     = st__to_pop_4a[1:0];
        push_en     = (c__to_push_4a == UC_PUSHALU) || (c__to_push_4a == UC_PUSHIMM);
        uf_ev       = 1'b0;
        d1          = depth_q - DW'(pop_cnt);
        if (DW'(pop_cnt) > depth_q) begin
            uf_ev = 1'b1;
            d1    = '0;
        end
        of_ev       = push_en && (d1 == DW'(DEPTH));
        wr_en       = push_en && (d1 != DW'(DEPTH));
        d2          = d1 + DW'(wr_en);
        tos_idx     = d2 - DW'(1);
        nos_idx     = d2 - DW'(2);

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[d1[AW-1:0]] = st__to_push_4a;
        end

        depth_d = d2;
        // The write lands at d1, so the NOS slot (d2-2) is never the one being written.
        tos_d   = '0;
        nos_d   = '0;
        if (d2 != '0) begin
            tos_d = wr_en ? st__to_push_4a : mem_q[tos_idx[AW-1:0]];
        end
        if (d2 >= DW'(2)) begin
            nos_d = mem_q[nos_idx[AW-1:0]];
        end

        underflow_d = underflow_q | uf_ev;
        overflow_d  = overflow_q | of_ev;
        fault_pc_d  = fault_pc_q;
        if ((uf_ev || of_ev) && !underflow_q && !overflow_q) begin
            fault_pc_d = pc_4a;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            depth_q     <= '0;
            tos_q       <= '0;
            nos_q       <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            fault_pc_q  <= '0;
        end else begin
            depth_q     <= depth_d;
            tos_q       <= tos_d;
            nos_q       <= nos_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    assign st__tos       = tos_q;
    assign st__nos       = nos_q;
    assign st__depth     = depth_q;
    assign st__underflow = underflow_q;
    assign st__overflow  = overflow_q;
    assign st__fault_pc  = fault_pc_q;
endmodule

// File: tb/tb_cpu_stack_writeback.sv
// tb/tb_cpu_stack_writeback.sv - vector table, directed corners and random queue-model check of cpu_stack_writeback
module tb_cpu_stack_writeback;
    localparam int         DEPTH        = 16;
    localparam int         DW           = 5;
    localparam logic [1:0] UC_PUSHALU   = 2'd1;
    localparam logic [1:0] UC_PUSHIMM   = 2'd2;
    localparam logic [2:0] TYPE_INTEGER = 3'd1;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic [1:0]    c_push = '0;
    logic [31:0]   pc = '0;
    logic [10:0]   pop = '0;
    logic [34:0]   val = '0;
    logic [34:0]   tos, nos;
    logic [DW-1:0] depth;
    logic          unf, ovf;
    logic [31:0]   fpc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_stack_writeback #(.DEPTH(DEPTH), .DW(DW), .UC_PUSHALU(UC_PUSHALU), .UC_PUSHIMM(UC_PUSHIMM)) dut (
        .clk(clk), .rst_b(rst_b), .c__to_push_4a(c_push), .pc_4a(pc),
        .st__to_pop_4a(pop), .st__to_push_4a(val), .st__tos(tos), .st__nos(nos),
        .st__depth(depth), .st__underflow(unf), .st__overflow(ovf), .st__fault_pc(fpc)
    );

    typedef struct {
        logic [1:0]    ctl;
        logic [31:0]   pc;
        logic [10:0]   pop;
        logic [34:0]   val;
        logic [DW-1:0] d;
        logic [34:0]   tos;
        logic [34:0]   nos;
        logic          unf;
        logic          ovf;
        logic [31:0]   fpc;
    } vec_t;

    vec_t tbl [12];

    // reference model state
    logic [34:0] mq [$];
    logic        m_unf, m_ovf;
    logic [31:0] m_fpc;

    task automatic check(input string name, input logic [DW-1:0] ed, input logic [34:0] et, input logic [34:0] en,
                         input logic eu, input logic eo, input logic [31:0] ef);
        vectors++;
        if ({depth, tos, nos, unf, ovf, fpc} !== {ed, et, en, eu, eo, ef}) begin
            miscompares++;
            $display("FAIL %s: got depth=%0d tos=%h nos=%h unf=%b ovf=%b fpc=%h, want depth=%0d tos=%h nos=%h unf=%b ovf=%b fpc=%h",
                     name, depth, tos, nos, unf, ovf, fpc, ed, et, en, eu, eo, ef);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [31:0] p, input logic [10:0] po, input logic [34:0] v);
        c_push = c; pc = p; pop = po; val = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        c_push = '0; pop = '0; val = '0; pc = '0;
        #2;
        rst_b = 1'b1;
        mq.delete();
        m_unf = 1'b0; m_ovf = 1'b0; m_fpc = '0;
    endtask

    task automatic model_step(input logic [1:0] c, input logic [31:0] p, input logic [10:0] po, input logic [34:0] v);
        int  n;
        bit  ue, oe;
        n  = int'(po[1:0]);
        ue = 0; oe = 0;
        if (n > mq.size()) begin
            mq.delete();
            ue = 1;
        end else begin
            repeat (n) void'(mq.pop_back());
        end
        if (c == UC_PUSHALU || c == UC_PUSHIMM) begin
            if (mq.size() < DEPTH) mq.push_back(v);
            else oe = 1;
        end
        if ((ue || oe) && !m_unf && !m_ovf) m_fpc = p;
        m_unf = m_unf | ue;
        m_ovf = m_ovf | oe;
    endtask

    function automatic logic [34:0] m_tos();
        return (mq.size() >= 1) ? mq[mq.size()-1] : 35'h0;
    endfunction

    function automatic logic [34:0] m_nos();
        return (mq.size() >= 2) ? mq[mq.size()-2] : 35'h0;
    endfunction

    initial begin
        logic [1:0]  rc;
        logic [31:0] rp;
        logic [10:0] rpo;
        logic [34:0] rv;

        for (int i = 0; i < 5; i++)
            tbl[i] = '{2'd0, 32'h0, 11'h0, 35'h0, 5'd0, 35'h0, 35'h0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{UC_PUSHIMM, 32'h10, 11'h0, 35'h1_0000_00AA, 5'd1, 35'h1_0000_00AA, 35'h0, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{UC_PUSHALU, 32'h14, 11'h0, {TYPE_INTEGER, 32'h55}, 5'd2, 35'h1_0000_0055, 35'h1_0000_00AA, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{UC_PUSHIMM, 32'h18, 11'h2, 35'h7, 5'd1, 35'h7, 35'h0, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{2'd0, 32'h100, 11'h3, 35'h0, 5'd0, 35'h0, 35'h0, 1'b1, 1'b0, 32'h100};
        tbl[9]  = '{2'd3, 32'h200, 11'h3, 35'h0, 5'd0, 35'h0, 35'h0, 1'b1, 1'b0, 32'h100};
        tbl[10] = '{UC_PUSHALU, 32'h204, 11'h0, 35'h5, 5'd1, 35'h5, 35'h0, 1'b1, 1'b0, 32'h100};
        tbl[11] = '{2'd3, 32'h208, 11'h7FC, {35{1'bx}}, 5'd1, 35'h5, 35'h0, 1'b1, 1'b0, 32'h100};

        @(posedge clk);
        #1;
        do_reset();
        check("reset", '0, '0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].ctl, tbl[i].pc, tbl[i].pop, tbl[i].val);
            check($sformatf("tbl%0d", i), tbl[i].d, tbl[i].tos, tbl[i].nos, tbl[i].unf, tbl[i].ovf, tbl[i].fpc);
        end

        // fill to DEPTH, then overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(UC_PUSHIMM, 32'h20 + i, 11'h0, 35'h2_0000_0000 + i);
            check($sformatf("fill%0d", i), DW'(i + 1), 35'h2_0000_0000 + i,
                  (i == 0) ? 35'h0 : 35'h2_0000_0000 + i - 1, 1'b0, 1'b0, 32'h0);
        end
        drive(UC_PUSHALU, 32'h40, 11'h0, 35'h4_DEAD_BEEF);
        check("overflow", 5'd16, 35'h2_0000_000F, 35'h2_0000_000E, 1'b0, 1'b1, 32'h40);
        drive(UC_PUSHIMM, 32'h44, 11'h1, 35'h3_1234_5678);
        check("full_replace", 5'd16, 35'h3_1234_5678, 35'h2_0000_000E, 1'b0, 1'b1, 32'h40);

        // async reset mid-cycle at depth 5 with a flag set
        do_reset();
        drive(2'd0, 32'h300, 11'h1, 35'h0);
        for (int i = 0; i < 5; i++) drive(UC_PUSHIMM, 32'h304, 11'h0, 35'h6_0000_0000 + i);
        check("pre_async", 5'd5, 35'h6_0000_0004, 35'h6_0000_0003, 1'b1, 1'b0, 32'h300);
        #2;
        rst_b = 1'b0;
        #1;
        check("async_reset", '0, '0, '0, 1'b0, 1'b0, '0);
        #1;
        rst_b = 1'b1;
        c_push = '0; pop = '0;
        @(posedge clk);
        #1;
        check("post_reset", '0, '0, '0, 1'b0, 1'b0, '0);

        // random against queue model; first half push-heavy to reach full
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rc  = 2'($urandom_range(0, 3));
            if (i < 200 && $urandom_range(0, 3) != 0) rc = ($urandom_range(0, 1) != 0) ? UC_PUSHALU : UC_PUSHIMM;
            rpo = 11'($urandom);
            if (i < 200 && $urandom_range(0, 3) != 0) rpo[1:0] = 2'd0;
            rv  = {3'($urandom), 32'($urandom)};
            rp  = 32'($urandom);
            drive(rc, rp, rpo, rv);
            model_step(rc, rp, rpo, rv);
            check($sformatf("rand%0d", i), DW'(mq.size()), m_tos(), m_nos(), m_unf, m_ovf, m_fpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpu_stack_writeback.md
Name: cpu_stack_writeback

Overview:
- Stage-4 consumer of the pipeline stack-update interface.
- Applies the per-instruction pop count and optional 35-bit tagged push to the architectural operand stack.
- Presents registered top-of-stack (TOS) and next-on-stack (NOS) entries, current depth and sticky fault flags back to decode/execute.
- Sole owner of operand-stack storage; one update per cycle, no stall.

Parameters:
- DEPTH, 16, number of 35-bit stack entries (power of two, >= 4).
- DW, 5, depth counter width; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_b  input  1  asynchronous active-low reset.
- c__to_push_4a  input  2  push control, opcode.vh codes: `UC_PUSHALU` or `UC_PUSHIMM` = push; any other value = no push.
- pc_4a  input  32  PC of the instruction in stage 4.
- st__to_pop_4a  input  11  [1:0] = entries to pop (0..3); [10:2] reserved, ignored.
- st__to_push_4a  input  35  tagged value to push ([34:32] type, [31:0] data); ignored when not pushing.
- st__tos  output  35  entry at depth-1; 35'h0 when depth==0.
- st__nos  output  35  entry at depth-2; 35'h0 when depth<2.
- st__depth  output  DW  current entry count, 0..DEPTH.
- st__underflow  output  1  sticky: a pop exceeded depth.
- st__overflow  output  1  sticky: a push was dropped on a full stack.
- st__fault_pc  output  32  pc_4a of the first fault since reset.

Behaviour:
- Reset (async assert, any cycle including mid-update):
  - st__depth=0; st__tos=35'h0; st__nos=35'h0.
  - st__underflow=0; st__overflow=0; st__fault_pc=32'h0.
  - Storage entries need not be cleared.
  - The first edge after deassertion processes inputs normally.
- Each cycle, combinationally: pop count p=st__to_pop_4a[1:0]; push enable u=(c__to_push_4a==`UC_PUSHALU || c__to_push_4a==`UC_PUSHIMM).
- Order within one cycle: pop first, then push. Pop+push in the same cycle replaces entries; it is legal and one-cycle.
- Pop:
  - If p<=depth: d1=depth-p.
  - If p>depth: d1=0 and underflow event.
- Push:
  - If u && d1<DEPTH: entry[d1]<=st__to_push_4a and d2=d1+1.
  - If u && d1==DEPTH: push dropped, d2=d1, overflow event.
  - If !u: d2=d1 and storage is unchanged.
- Register updates:
  - st__depth<=d2.
  - st__tos/st__nos<=entries at d2-1/d2-2 of the post-update stack.
  - The pushed value is bypassed directly into st__tos in the same edge; no stale read.
- Latency: exactly 1 cycle. Inputs at edge N are reflected in all outputs after edge N.
- Depth arithmetic is DW bits unsigned, never wraps: clamped at 0 (underflow) and DEPTH (overflow).
- Faults:
  - Flags are sticky until reset.
  - st__fault_pc captures pc_4a only when the event occurs while both flags are still 0.
  - If underflow and overflow occur together, both flags set and one PC is captured.
  - Stack operation continues normally after a fault.
- Reserved bits of st__to_pop_4a and the push value content never affect control.
- X on st__to_push_4a is tolerated when u=0; it must not propagate to any output.

Test Plan:
- Reset, then hold p=0 with no push -> depth=0, tos=nos=35'h0, flags 0, fault_pc 0 for 5 cycles.
- Push `UC_PUSHIMM` 35'h1_0000_00AA, then `UC_PUSHALU` {`TYPE_INTEGER`,32'h55} on consecutive cycles -> depth 1 then 2; tos={`TYPE_INTEGER`,32'h55}, nos=35'h1_0000_00AA one cycle after each push.
- With depth=2, apply p=2 plus push 35'h7 in one cycle -> depth=1, tos=35'h7, nos=0, no flags.
- With depth=1, pc_4a=32'h100, p=3 -> depth=0, underflow=1, fault_pc=32'h100. A later underflow at pc_4a=32'h200 leaves fault_pc=32'h100.
- Fill to DEPTH=16, then push at pc_4a=32'h40 -> depth stays 16, overflow=1, tos unchanged, fault_pc=32'h40. Then p=1 with push -> tos=new value, depth 16.
- Assert rst_b low mid-sequence at depth 5 with flags set -> all outputs zero immediately (asynchronously), before the next edge.
